// File: rtl/seq_alu_if.sv
// seq_alu_if: request/operand and result/status bundle for seq_alu.
// The master side issues operations; the slave side is the ALU.
interface seq_alu_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
);
    logic                  startIn;
    logic [3:0]            funcIn;
    logic [DATA_WIDTH-1:0] fIn;
    logic [DATA_WIDTH-1:0] wIn;
    logic [SEL_WIDTH-1:0]  bitSel;
    logic                  cFlag;
    logic                  busyOut;
    logic                  doneOut;
    logic [DATA_WIDTH-1:0] resultOut;
    logic [DATA_WIDTH-1:0] resultHiOut;
    logic [2:0]            statusOut;

    modport master (
        output startIn, funcIn, fIn, wIn, bitSel, cFlag,
        input  busyOut, doneOut, resultOut, resultHiOut, statusOut
    );

    modport slave (
        input  startIn, funcIn, fIn, wIn, bitSel, cFlag,
        output busyOut, doneOut, resultOut, resultHiOut, statusOut
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: PIC-style sequential ALU, single-cycle ops plus iterative MUL.
// Define SEQ_ALU_MUL_EN to build the MUL datapath and MUL_RUN state.
module seq_alu #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);
    localparam int W = DATA_WIDTH;

    localparam logic [3:0] F_ADD   = 4'd0;
    localparam logic [3:0] F_SUB   = 4'd1;
    localparam logic [3:0] F_AND   = 4'd2;
    localparam logic [3:0] F_IOR   = 4'd3;
    localparam logic [3:0] F_XOR   = 4'd4;
    localparam logic [3:0] F_COMF  = 4'd5;
    localparam logic [3:0] F_INCF  = 4'd6;
    localparam logic [3:0] F_DECF  = 4'd7;
    localparam logic [3:0] F_RLF   = 4'd8;
    localparam logic [3:0] F_RRF   = 4'd9;
    localparam logic [3:0] F_SWAPF = 4'd10;
    localparam logic [3:0] F_BCF   = 4'd11;
    localparam logic [3:0] F_BSF   = 4'd12;

    logic [W-1:0] res_q, res_d;
    logic [W-1:0] res_hi_q, res_hi_d;
    logic [2:0]   stat_q, stat_d;
    logic         done_q, done_d;
    logic         busy;
    logic         accept;

    logic [W-1:0] alu_res;
    logic [W:0]   alu_sum;
    logic [W-1:0] alu_mask;
    logic         alu_dc;
    logic         alu_c;
    logic         alu_def;

`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] F_MUL = 4'd13;
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MUL_RUN = 1'b1;
    localparam logic [SEL_WIDTH:0] LAST = (SEL_WIDTH+1)'(W - 1);
    localparam logic [SEL_WIDTH:0] ONE  = (SEL_WIDTH+1)'(1);

    logic [0:0]         state_q, state_d;
    logic [W-1:0]       mcand_q, mcand_d;
    logic [W-1:0]       acc_hi_q, acc_hi_d;
    logic [W-1:0]       acc_lo_q, acc_lo_d;
    logic [SEL_WIDTH:0] cnt_q, cnt_d;
    logic [W:0]         psum;

    assign busy = (state_q == S_MUL_RUN);
`else
    assign busy = 1'b0;
`endif

    assign accept          = bus.startIn && !busy;
    assign bus.busyOut     = busy;
    assign bus.doneOut     = done_q;
    assign bus.resultOut   = res_q;
    assign bus.resultHiOut = res_hi_q;
    assign bus.statusOut   = stat_q;

    // Single-cycle function datapath; undefined codes yield all-ones
    always_comb begin
        alu_res  = '1;
        alu_sum  = '0;
        alu_dc   = 1'b0;
        alu_c    = 1'b0;
        alu_def  = 1'b1;
        alu_mask = {{(W-1){1'b0}}, 1'b1} << bus.bitSel;
        case (bus.funcIn)
            F_ADD: begin
                alu_sum = {1'b0, bus.fIn} + {1'b0, bus.wIn};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
                alu_dc  = bus.fIn[4] ^ bus.wIn[4] ^ alu_sum[4];
            end
            F_SUB: begin
                alu_sum = {1'b0, bus.fIn} + {1'b0, ~bus.wIn}
                        + {{W{1'b0}}, 1'b1};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
                alu_dc  = bus.fIn[4] ^ ~bus.wIn[4] ^ alu_sum[4];
            end
            F_AND:   alu_res = bus.fIn & bus.wIn;
            F_IOR:   alu_res = bus.fIn | bus.wIn;
            F_XOR:   alu_res = bus.fIn ^ bus.wIn;
            F_COMF:  alu_res = ~bus.fIn;
            F_INCF:  alu_res = bus.fIn + {{(W-1){1'b0}}, 1'b1};
            F_DECF:  alu_res = bus.fIn - {{(W-1){1'b0}}, 1'b1};
            F_RLF: begin
                alu_res = {bus.fIn[W-2:0], bus.cFlag};
                alu_c   = bus.fIn[W-1];
            end
            F_RRF: begin
                alu_res = {bus.cFlag, bus.fIn[W-1:1]};
                alu_c   = bus.fIn[0];
            end
            F_SWAPF: alu_res = {bus.fIn[W/2-1:0], bus.fIn[W-1:W/2]};
            F_BCF:   alu_res = bus.fIn & ~alu_mask;
            F_BSF:   alu_res = bus.fIn | alu_mask;
            default: alu_def = 1'b0;
        endcase
    end

    // Result capture, done pulse and shift-add MUL sequencing
    always_comb begin
        res_d    = res_q;
        res_hi_d = res_hi_q;
        stat_d   = stat_q;
        done_d   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        psum     = {1'b0, acc_hi_q}
                 + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        if (state_q == S_MUL_RUN) begin
            {acc_hi_d, acc_lo_d} = {psum, acc_lo_q[W-1:1]};
            cnt_d = cnt_q + ONE;
            if (cnt_q == LAST) begin
                state_d  = S_IDLE;
                res_d    = acc_lo_d;
                res_hi_d = acc_hi_d;
                stat_d   = {({acc_hi_d, acc_lo_d} == '0), 1'b0,
                            (acc_hi_d != '0)};
                done_d   = 1'b1;
            end
        end else if (accept && (bus.funcIn == F_MUL)) begin
            state_d  = S_MUL_RUN;
            mcand_d  = bus.fIn;
            acc_hi_d = '0;
            acc_lo_d = bus.wIn;
            cnt_d    = '0;
        end else
`endif
        if (accept) begin
            res_d    = alu_res;
            res_hi_d = '0;
            stat_d   = alu_def ? {(alu_res == '0), alu_dc, alu_c} : 3'b000;
            done_d   = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q    <= '0;
            res_hi_q <= '0;
            stat_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            stat_q   <= stat_d;
            done_q   <= done_d;
        end
    end

`ifdef SEQ_ALU_MUL_EN
    // Multiplier state; reset aborts any MUL in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end
`endif
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result width; legal values are even and >= 8.
REQ-002 SHALL have parameter SEL_WIDTH, default 3, bit-select width, equal to log2(DATA_WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port startIn  input  1  request to begin an operation.
REQ-006 SHALL have port funcIn  input  4  function code: 0 ADD, 1 SUB, 2 AND, 3 IOR, 4 XOR, 5 COMF, 6 INCF, 7 DECF, 8 RLF, 9 RRF, 10 SWAPF, 11 BCF, 12 BSF, 13 MUL; 14-15 undefined.
REQ-007 SHALL have port fIn  input  DATA_WIDTH  file operand.
REQ-008 SHALL have port wIn  input  DATA_WIDTH  working/literal operand.
REQ-009 SHALL have port bitSel  input  SEL_WIDTH  bit index for BCF/BSF.
REQ-010 SHALL have port cFlag  input  1  carry in for RLF/RRF.
REQ-011 SHALL have port busyOut  output  1  multi-cycle operation in progress.
REQ-012 SHALL have port doneOut  output  1  one-cycle pulse: result valid.
REQ-013 SHALL have port resultOut  output  DATA_WIDTH  result (MUL: low half).
REQ-014 SHALL have port resultHiOut  output  DATA_WIDTH  MUL high half; zero for all other functions.
REQ-015 SHALL have port statusOut  output  3  {zero, digit carry, carry}.

Function
REQ-016 SHALL sample startIn, funcIn, fIn, wIn, bitSel and cFlag only on a rising edge where busyOut=0; startIn while busyOut=1 is ignored.
REQ-017 SHALL complete non-MUL functions at the sampling edge: resultOut, resultHiOut and statusOut register at that edge, doneOut=1 for the following cycle only, and busyOut stays 0.
REQ-018 SHALL compute ADD as f+w and SUB as f-w; C = carry out of the MSB (SUB: 1 = no borrow); DC = carry out of bit 3 (SUB: 1 = no borrow from bit 3).
REQ-019 SHALL compute INCF/DECF as f+1/f-1 modulo 2^DATA_WIDTH, with DC=C=0.
REQ-020 SHALL compute RLF as {C,result} = {f,cFlag} and RRF as {C,result} = {f[0],cFlag,f[MSB:1]}.
REQ-021 SHALL compute SWAPF by exchanging the upper and lower halves of f; BCF/BSF clear/set bit bitSel of f; AND/IOR/XOR/COMF as bitwise ops.
REQ-022 SHALL set Z = (resultOut == 0) for every function except MUL; DC and C are 0 except where REQ-018/REQ-020 define them.
REQ-023 SHALL implement MUL as an unsigned iterative shift-add with two states, IDLE and MUL_RUN: IDLE->MUL_RUN on an accepted MUL start, MUL_RUN->IDLE after DATA_WIDTH iterations.
REQ-024 SHALL drive busyOut=1 from the edge after acceptance through the final iteration edge; a MUL accepted at edge N produces doneOut=1 after edge N+DATA_WIDTH, and busyOut falls at that same edge.
REQ-025 SHALL set MUL status to Z = (full product == 0), DC=0, C = (resultHiOut != 0).
REQ-026 SHALL give an undefined function code all-ones resultOut, zero resultHiOut and status 000, completing in one cycle.
REQ-027 SHALL hold resultOut, resultHiOut and statusOut stable between completions.

Reset
REQ-028 SHALL on rst_n=0 immediately force the state to IDLE and drive busyOut=0, doneOut=0, resultOut=0, resultHiOut=0 and statusOut=000, including mid-MUL; the aborted MUL produces no doneOut.
REQ-029 SHALL accept a start on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL include the MUL datapath and MUL_RUN state only when the macro SEQ_ALU_MUL_EN is defined; without it, code 13 behaves as an undefined code (REQ-026) and busyOut is tied to 0.

Verification
REQ-031 SHALL cover: ADD f=0x0F, w=0x01 -> resultOut=0x10, status 010, doneOut one cycle after start.
REQ-032 SHALL cover: SUB f=0x05, w=0x05 -> resultOut=0x00, status 111; SUB f=0x00, w=0x01 -> resultOut=0xFF, status 000.
REQ-033 SHALL cover: RRF f=0x01, cFlag=1 -> resultOut=0x80, status 001; BSF f=0x00, bitSel=7 -> resultOut=0x80.
REQ-034 SHALL cover (macro on): MUL 0xFF*0xFF -> busyOut high 8 cycles, then resultOut=0x01, resultHiOut=0xFE, status 001; an ADD start issued at cycle 3 is ignored.
REQ-035 SHALL cover: rst_n pulsed low during MUL iteration 4 -> outputs zero, no doneOut; next MUL 0x03*0x04 -> resultOut=0x0C after 8 cycles.
REQ-036 SHALL cover (macro off): MUL 0x02*0x03 -> one-cycle completion, resultOut=0xFF, status 000, busyOut never 1.
